// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared encodings, defaults and per-FU lookup helpers for issue_scoreboard
package issue_pkg;

    localparam logic [1:0] NUMOP_NONE = 2'd0;
    localparam logic [1:0] NUMOP_A    = 2'd1;
    localparam logic [1:0] NUMOP_AB   = 2'd2;

    localparam int unsigned FU_MAX          = 16;
    localparam logic [15:0] FU_LAT_DEFAULT  = {4'd1, 4'd4, 4'd2, 4'd1};
    localparam logic [3:0]  FU_PIPE_DEFAULT = 4'b1101;

    // Lookups take zero-extended vectors so one helper serves any FU count up to FU_MAX.
    function automatic logic [3:0] lat_of(input logic [4*FU_MAX-1:0] lat_vec, input logic [3:0] fu);
        return lat_vec[{fu, 2'b00} +: 4];
    endfunction

    function automatic logic pipe_of(input logic [FU_MAX-1:0] pipe_vec, input logic [3:0] fu);
        return pipe_vec[fu];
    endfunction

endpackage

// File: rtl/issue_sb_entry.sv
// rtl/issue_sb_entry.sv - pending bit and latency countdown for one architectural register
module issue_sb_entry (
    input  logic       clock,
    input  logic       reset,
    input  logic       set_i,
    input  logic [3:0] lat_i,
    input  logic       hold_i,
    input  logic       clear_i,
    output logic       pending_o
);

    logic       pend_q, pend_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            pend_d = 1'b0;
            cnt_d  = 4'd0;
        end else if (set_i) begin
            pend_d = 1'b1;
            cnt_d  = lat_i;
        end else if (pend_q && cnt_q != 4'd0 && !hold_i) begin
            // Pending stays high through the cycle where cnt is 1, so a WAW re-set never races the clear.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - in-order issue stage with latency-counting register scoreboard
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int unsigned          NREGS   = 32,
    parameter int unsigned          DATA_W  = 32,
    parameter int unsigned          NUM_FU  = 4,
    parameter logic [4*NUM_FU-1:0]  FU_LAT  = FU_LAT_DEFAULT,
    parameter logic [NUM_FU-1:0]    FU_PIPE = FU_PIPE_DEFAULT,
    parameter int unsigned          CTRL_W  = 24,
    localparam int unsigned         REG_AW  = $clog2(NREGS),
    localparam int unsigned         FU_W    = $clog2(NUM_FU)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_is_valid,
    output logic              id_is_ready,
    input  logic [REG_AW-1:0] id_is_addra,
    input  logic [REG_AW-1:0] id_is_addrb,
    input  logic [1:0]        id_is_numop,
    input  logic [REG_AW-1:0] id_is_regdest,
    input  logic              id_is_writereg,
    input  logic [FU_W-1:0]   id_is_fununit,
    input  logic [CTRL_W-1:0] id_is_ctrl,
    output logic [REG_AW-1:0] is_reg_addra,
    output logic [REG_AW-1:0] is_reg_addrb,
    input  logic [DATA_W-1:0] reg_is_dataa,
    input  logic [DATA_W-1:0] reg_is_datab,
    output logic              is_ex_valid,
    input  logic              is_ex_ready,
    output logic [FU_W-1:0]   is_ex_fununit,
    output logic [REG_AW-1:0] is_ex_regdest,
    output logic              is_ex_writereg,
    output logic [CTRL_W-1:0] is_ex_ctrl,
    output logic [DATA_W-1:0] is_ex_rega,
    output logic [DATA_W-1:0] is_ex_regb,
    input  logic              flush,
    output logic [NREGS-1:0]  is_pending
);

    logic [NREGS-1:0]       pending;
    logic [NUM_FU-1:0][3:0] busy_q, busy_d;

    logic              ex_valid_q, ex_valid_d;
    logic [FU_W-1:0]   ex_fununit_q, ex_fununit_d;
    logic [REG_AW-1:0] ex_regdest_q, ex_regdest_d;
    logic              ex_writereg_q, ex_writereg_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [DATA_W-1:0] ex_rega_q, ex_rega_d;
    logic [DATA_W-1:0] ex_regb_q, ex_regb_d;

    logic       raw_haz, waw_haz, str_haz;
    logic       fire, ex_hs, flush_kill;
    logic [3:0] id_lat;

    assign is_reg_addra = id_is_addra;
    assign is_reg_addrb = id_is_addrb;

    assign raw_haz = (id_is_numop != NUMOP_NONE && pending[id_is_addra])
                  || (id_is_numop == NUMOP_AB && pending[id_is_addrb]);
    assign waw_haz = id_is_writereg && pending[id_is_regdest];
    // A non-pipelined FU is also occupied while its previous op still sits in the output register.
    assign str_haz = (busy_q[id_is_fununit] != 4'd0)
                  || (ex_valid_q && ex_fununit_q == id_is_fununit
                      && !pipe_of(16'(FU_PIPE), 4'(id_is_fununit)));

    assign id_is_ready = !(raw_haz || waw_haz || str_haz) && (!ex_valid_q || is_ex_ready) && !flush;
    assign fire        = id_is_valid && id_is_ready;
    assign ex_hs       = ex_valid_q && is_ex_ready;
    assign flush_kill  = flush && ex_valid_q && !is_ex_ready;
    assign id_lat      = lat_of(64'(FU_LAT), 4'(id_is_fununit));

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_fununit_d  = ex_fununit_q;
        ex_regdest_d  = ex_regdest_q;
        ex_writereg_d = ex_writereg_q;
        ex_ctrl_d     = ex_ctrl_q;
        ex_rega_d     = ex_rega_q;
        ex_regb_d     = ex_regb_q;
        if (fire) begin
            ex_valid_d    = 1'b1;
            ex_fununit_d  = id_is_fununit;
            ex_regdest_d  = id_is_regdest;
            ex_writereg_d = id_is_writereg;
            ex_ctrl_d     = id_is_ctrl;
            ex_rega_d     = reg_is_dataa;
            ex_regb_d     = reg_is_datab;
        end else if (is_ex_ready || flush) begin
            ex_valid_d = 1'b0;
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int f = 0; f < NUM_FU; f++) begin
            if (!FU_PIPE[f]) begin
                if (ex_hs && ex_fununit_q == FU_W'(f)) begin
                    busy_d[f] = lat_of(64'(FU_LAT), 4'(f));
                end else if (busy_q[f] != 4'd0) begin
                    busy_d[f] = busy_q[f] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_fununit_q  <= '0;
            ex_regdest_q  <= '0;
            ex_writereg_q <= 1'b0;
            ex_ctrl_q     <= '0;
            ex_rega_q     <= '0;
            ex_regb_q     <= '0;
            busy_q        <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_fununit_q  <= ex_fununit_d;
            ex_regdest_q  <= ex_regdest_d;
            ex_writereg_q <= ex_writereg_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_rega_q     <= ex_rega_d;
            ex_regb_q     <= ex_regb_d;
            busy_q        <= busy_d;
        end
    end

    assign pending[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_entry
        logic dest_hit;
        assign dest_hit = (ex_regdest_q == REG_AW'(r));
        issue_sb_entry u_entry (
            .clock     (clock),
            .reset     (reset),
            .set_i     (fire && id_is_writereg && id_is_regdest == REG_AW'(r)),
            .lat_i     (id_lat),
            .hold_i    (ex_valid_q && !is_ex_ready && dest_hit),
            .clear_i   (flush_kill && ex_writereg_q && dest_hit),
            .pending_o (pending[r])
        );
    end

    assign is_pending     = pending;
    assign is_ex_valid    = ex_valid_q;
    assign is_ex_fununit  = ex_fununit_q;
    assign is_ex_regdest  = ex_regdest_q;
    assign is_ex_writereg = ex_writereg_q;
    assign is_ex_ctrl     = ex_ctrl_q;
    assign is_ex_rega     = ex_rega_q;
    assign is_ex_regb     = ex_regb_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - self-checking scoreboard bench for issue_scoreboard
module tb_issue_scoreboard;

    localparam int LAT1 = 2;
    localparam int LAT2 = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_is_valid;
    logic        id_is_ready;
    logic [4:0]  id_is_addra, id_is_addrb, id_is_regdest;
    logic [1:0]  id_is_numop;
    logic        id_is_writereg;
    logic [1:0]  id_is_fununit;
    logic [23:0] id_is_ctrl;
    logic [4:0]  is_reg_addra, is_reg_addrb;
    logic [31:0] reg_is_dataa, reg_is_datab;
    logic        is_ex_valid;
    logic        is_ex_ready;
    logic [1:0]  is_ex_fununit;
    logic [4:0]  is_ex_regdest;
    logic        is_ex_writereg;
    logic [23:0] is_ex_ctrl;
    logic [31:0] is_ex_rega, is_ex_regb;
    logic        flush;
    logic [31:0] is_pending;

    typedef struct packed {
        logic [1:0]  fu;
        logic [4:0]  dest;
        logic        wr;
        logic [23:0] ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   hs_cyc[256];
    int   st;

    issue_scoreboard dut (
        .clock          (clock),
        .reset          (reset),
        .id_is_valid    (id_is_valid),
        .id_is_ready    (id_is_ready),
        .id_is_addra    (id_is_addra),
        .id_is_addrb    (id_is_addrb),
        .id_is_numop    (id_is_numop),
        .id_is_regdest  (id_is_regdest),
        .id_is_writereg (id_is_writereg),
        .id_is_fununit  (id_is_fununit),
        .id_is_ctrl     (id_is_ctrl),
        .is_reg_addra   (is_reg_addra),
        .is_reg_addrb   (is_reg_addrb),
        .reg_is_dataa   (reg_is_dataa),
        .reg_is_datab   (reg_is_datab),
        .is_ex_valid    (is_ex_valid),
        .is_ex_ready    (is_ex_ready),
        .is_ex_fununit  (is_ex_fununit),
        .is_ex_regdest  (is_ex_regdest),
        .is_ex_writereg (is_ex_writereg),
        .is_ex_ctrl     (is_ex_ctrl),
        .is_ex_rega     (is_ex_rega),
        .is_ex_regb     (is_ex_regb),
        .flush          (flush),
        .is_pending     (is_pending)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] data_of(input logic [4:0] a, input logic sel);
        return 32'hA55A_0000 ^ {sel, 10'd0, a, 11'd0, a};
    endfunction

    function automatic logic [23:0] mk_ctrl(input logic [7:0] tag);
        return {tag ^ 8'hC3, tag ^ 8'h5A, tag};
    endfunction

    assign reg_is_dataa = data_of(is_reg_addra, 1'b0);
    assign reg_is_datab = data_of(is_reg_addrb, 1'b1);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (is_ex_valid && is_ex_ready) begin
                hs_cyc[is_ex_ctrl[7:0]] = cyc;
                if (sb_q.size() == 0) begin
                    check_eq("sb_nonempty", 64'(sb_q.size()), 64'd1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("ex_ctrl", 64'(is_ex_ctrl), 64'(mon_e.ctrl));
                    check_eq("ex_meta", 64'({is_ex_fununit, is_ex_regdest, is_ex_writereg}),
                             64'({mon_e.fu, mon_e.dest, mon_e.wr}));
                    check_eq("ex_ops", {is_ex_rega, is_ex_regb}, {mon_e.a, mon_e.b});
                end
            end else if (flush && is_ex_valid && sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
            end
            if (id_is_valid && id_is_ready) begin
                sb_q.push_back('{fu: id_is_fununit, dest: id_is_regdest, wr: id_is_writereg,
                                 ctrl: id_is_ctrl, a: data_of(id_is_addra, 1'b0),
                                 b: data_of(id_is_addrb, 1'b1)});
            end
        end
    end

    task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [1:0] nop,
                         input logic [4:0] dest, input logic wr, input logic [1:0] fu,
                         input logic [7:0] tag);
        id_is_addra    = a;
        id_is_addrb    = b;
        id_is_numop    = nop;
        id_is_regdest  = dest;
        id_is_writereg = wr;
        id_is_fununit  = fu;
        id_is_ctrl     = mk_ctrl(tag);
        id_is_valid    = 1'b1;
    endtask

    // Called just after a rising edge; returns once the instruction has fired, with its stall count.
    task automatic send(input logic [4:0] a, input logic [4:0] b, input logic [1:0] nop,
                        input logic [4:0] dest, input logic wr, input logic [1:0] fu,
                        input logic [7:0] tag, output int stalls);
        logic fired;
        drive(a, b, nop, dest, wr, fu, tag);
        fired  = 1'b0;
        stalls = 0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clock);
            if (id_is_ready) begin
                fired = 1'b1;
                break;
            end
            stalls++;
        end
        check_eq("send_fired", 64'(fired), 64'd1);
        @(posedge clock);
        #1;
        id_is_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        is_ex_ready = 1'b1;
        flush       = 1'b0;
        drive(5'd1, 5'd2, 2'd2, 5'd3, 1'b1, 2'd0, 8'd1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_ex_valid", 64'(is_ex_valid), 64'd0);
        check_eq("rst_pending", 64'(is_pending), 64'd0);
        check_eq("rst_ex_fields", {is_ex_ctrl, is_ex_regdest, is_ex_writereg, is_ex_fununit},
                 64'd0);
        check_eq("rst_ex_ops", {is_ex_rega, is_ex_regb}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        send(5'd1, 5'd2, 2'd2, 5'd3, 1'b1, 2'd0, 8'd1, st);
        check_eq("first_accept_stalls", 64'(st), 64'd0);
        idle(1);

        // independent back-to-back issue
        send(5'd20, 5'd21, 2'd2, 5'd10, 1'b1, 2'd0, 8'd2, st);
        check_eq("b2b_0", 64'(st), 64'd0);
        send(5'd22, 5'd23, 2'd2, 5'd11, 1'b1, 2'd2, 8'd3, st);
        check_eq("b2b_1", 64'(st), 64'd0);
        send(5'd24, 5'd25, 2'd1, 5'd12, 1'b1, 2'd3, 8'd4, st);
        check_eq("b2b_2", 64'(st), 64'd0);
        idle(8);

        // WAW on r13 behind a latency-4 writer
        send(5'd1, 5'd1, 2'd0, 5'd13, 1'b1, 2'd2, 8'd5, st);
        send(5'd1, 5'd1, 2'd0, 5'd13, 1'b1, 2'd0, 8'd6, st);
        check_eq("waw_stalls", 64'(st), 64'(LAT2));
        idle(10);
        check_eq("idle_pending_0", 64'(is_pending), 64'd0);

        // RAW: producer on the latency-4 FU, consumer reads r5
        send(5'd1, 5'd2, 2'd2, 5'd5, 1'b1, 2'd2, 8'd10, st);
        send(5'd5, 5'd0, 2'd1, 5'd6, 1'b1, 2'd0, 8'd11, st);
        check_eq("raw_stalls", 64'(st), 64'(LAT2));
        idle(3);
        check_eq("raw_hs_gap", 64'(hs_cyc[11] - hs_cyc[10]), 64'(LAT2 + 1));
        idle(8);

        // writes to r0 never make anything pending
        send(5'd3, 5'd4, 2'd2, 5'd0, 1'b1, 2'd0, 8'd12, st);
        @(negedge clock);
        check_eq("r0_not_pending", 64'(is_pending), 64'd0);
        @(posedge clock);
        #1;
        send(5'd0, 5'd0, 2'd2, 5'd14, 1'b1, 2'd0, 8'd13, st);
        check_eq("r0_reader_stalls", 64'(st), 64'd0);
        idle(6);

        // backpressure freezes the held producer's countdown
        is_ex_ready = 1'b0;
        send(5'd1, 5'd2, 2'd0, 5'd7, 1'b1, 2'd1, 8'd14, st);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("bp_hold_r7", 64'(is_pending[7]), 64'd1);
        end
        @(posedge clock);
        #1;
        is_ex_ready = 1'b1;
        @(negedge clock);
        check_eq("bp_rel_0", 64'(is_pending[7]), 64'd1);
        @(negedge clock);
        check_eq("bp_rel_1", 64'(is_pending[7]), 64'd1);
        @(negedge clock);
        check_eq("bp_clear", 64'(is_pending[7]), 64'd0);
        @(posedge clock);
        #1;
        idle(8);

        // two ops to the non-pipelined FU1
        send(5'd1, 5'd2, 2'd0, 5'd0, 1'b0, 2'd1, 8'd20, st);
        send(5'd3, 5'd4, 2'd0, 5'd0, 1'b0, 2'd1, 8'd21, st);
        check_eq("busy_stalls", 64'(st), 64'(LAT1 + 1));
        idle(3);
        check_eq("busy_hs_gap", 64'(hs_cyc[21] - hs_cyc[20]), 64'(LAT1 + 2));
        idle(6);

        // flush of a held, unaccepted producer
        is_ex_ready = 1'b0;
        send(5'd1, 5'd2, 2'd0, 5'd9, 1'b1, 2'd0, 8'd30, st);
        @(negedge clock);
        check_eq("flush_pre_r9", 64'(is_pending[9]), 64'd1);
        @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        check_eq("flush_ex_valid", 64'(is_ex_valid), 64'd0);
        check_eq("flush_r9_cleared", 64'(is_pending[9]), 64'd0);
        @(posedge clock);
        #1;
        is_ex_ready = 1'b1;
        idle(2);

        // flush coincident with handshake keeps the entry
        send(5'd1, 5'd2, 2'd0, 5'd9, 1'b1, 2'd2, 8'd31, st);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        check_eq("flush_hs_ex_valid", 64'(is_ex_valid), 64'd0);
        check_eq("flush_hs_r9_kept", 64'(is_pending[9]), 64'd1);
        @(posedge clock);
        #1;
        idle(10);

        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        check_eq("end_pending", 64'(is_pending), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
